// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the instruction encoder: class/command codes, error codes,
// FSM state type and the captured request record.
package instr_encoder_pkg;

    localparam logic [1:0] CLASS_DP  = 2'b00;
    localparam logic [1:0] CLASS_MEM = 2'b01;
    localparam logic [1:0] CLASS_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] ERR_DECODE = 2'b00;
    localparam logic [1:0] ERR_NOIMM  = 2'b01;
    localparam logic [1:0] ERR_MEMOFF = 2'b10;
    localparam logic [1:0] ERR_BRANCH = 2'b11;

    typedef enum logic [1:0] {StIdle, StSearch, StEmit, StErr} state_t;

    typedef struct packed {
        logic [1:0]  cls;
        logic [3:0]  cond;
        logic [3:0]  cmd;
        logic        s;
        logic        imm;
        logic        load;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic [31:0] imm32;
        logic [31:0] target;
    } req_t;

    function automatic logic dp_cmd_ok(input logic [3:0] cmd);
        return cmd inside {CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_CMP, CMD_EOR};
    endfunction

    // Byte offset from the PC (write address + 8) to the branch target.
    function automatic logic [31:0] branch_offset(input logic [31:0] target,
                                                  input logic [31:0] pc);
        return target - (pc + 32'd8);
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational assembly of a 32-bit instruction word from a request record.
module instr_field_pack
    import instr_encoder_pkg::*;
(
    input  req_t        req,
    input  logic [31:0] pc,
    input  logic [3:0]  rot,
    input  logic [7:0]  imm8,
    output logic [31:0] word
);

    logic [31:0] off;
    logic [31:0] mag;
    logic        is_cmp;
    logic        s_bit;
    logic [3:0]  rd_f;
    logic [11:0] src2;
    logic        unused_bits;

    always_comb begin
        off    = branch_offset(req.target, pc);
        mag    = req.imm32[31] ? (32'd0 - req.imm32) : req.imm32;
        is_cmp = (req.cmd == CMD_CMP);
        s_bit  = req.s | is_cmp;
        rd_f   = is_cmp ? 4'd0 : req.rd;
        src2   = req.imm ? {rot, imm8} : {8'h00, req.rm};
        word   = '0;
        case (req.cls)
            CLASS_DP:  word = {req.cond, 2'b00, req.imm, req.cmd, s_bit, req.rn, rd_f, src2};
            CLASS_MEM: word = {req.cond, 2'b01, 1'b0, 1'b1, ~req.imm32[31], 1'b0, 1'b0,
                               req.load, req.rn, req.rd, mag[11:0]};
            CLASS_BR:  word = {req.cond, 4'b1010, off[25:2]};
            default:   word = '0;
        endcase
    end

    assign unused_bits = ^{off[31:26], off[1:0], mag[31:12]};

endmodule

// File: rtl/instr_encoder.sv
// Request-driven instruction encoder: validates, searches DP immediate rotations,
// and writes encoded words to sequential instruction-memory addresses.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [1:0]  in_class,
    input  logic [3:0]  in_cond,
    input  logic [3:0]  in_cmd,
    input  logic        in_s,
    input  logic        in_imm,
    input  logic        in_load,
    input  logic [3:0]  in_rn,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_rm,
    input  logic [31:0] in_imm32,
    input  logic [31:0] in_target,
    output logic        in_ready,
    input  logic        restart,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        err,
    output logic [1:0]  err_code
);

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  rot_q, rot_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;

    req_t        in_req, cur_req;
    logic [31:0] pc, br_off, packed_word, rol;
    logic [63:0] rol_dbl;
    logic        hit, mem_bad, br_bad, unused_rol;

    always_comb begin
        in_req        = '0;
        in_req.cls    = in_class;
        in_req.cond   = in_cond;
        in_req.cmd    = in_cmd;
        in_req.s      = in_s;
        in_req.imm    = in_imm;
        in_req.load   = in_load;
        in_req.rn     = in_rn;
        in_req.rd     = in_rd;
        in_req.rm     = in_rm;
        in_req.imm32  = in_imm32;
        in_req.target = in_target;
    end

    // Live inputs are packed on the accept edge; captured fields thereafter.
    assign cur_req = (state_q == StIdle) ? in_req : req_q;
    assign pc      = (state_q == StIdle && restart) ? BASE_ADDR : addr_q;

    assign rol_dbl    = {req_q.imm32, req_q.imm32} << {rot_q, 1'b0};
    assign rol        = rol_dbl[63:32];
    assign hit        = (rol[31:8] == 24'd0);
    assign unused_rol = ^rol_dbl[31:0];

    assign br_off  = branch_offset(in_target, pc);
    assign br_bad  = (in_target[1:0] != 2'b00) ||
                     !((br_off[31:25] == 7'h00) || (br_off[31:25] == 7'h7f));
    assign mem_bad = ($signed(in_imm32) > 32'sd4095) || ($signed(in_imm32) < -32'sd4095);

    instr_field_pack u_pack (
        .req  (cur_req),
        .pc   (pc),
        .rot  (rot_q),
        .imm8 (rol[7:0]),
        .word (packed_word)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        rot_d      = rot_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        unique case (state_q)
            StIdle: begin
                if (restart) addr_d = BASE_ADDR;
                if (in_valid) begin
                    req_d = in_req;
                    rot_d = 4'd0;
                    if (in_class == 2'b11 || (in_class == CLASS_DP && !dp_cmd_ok(in_cmd))) begin
                        state_d    = StErr;
                        err_d      = 1'b1;
                        err_code_d = ERR_DECODE;
                    end else if (in_class == CLASS_MEM && mem_bad) begin
                        state_d    = StErr;
                        err_d      = 1'b1;
                        err_code_d = ERR_MEMOFF;
                    end else if (in_class == CLASS_BR && br_bad) begin
                        state_d    = StErr;
                        err_d      = 1'b1;
                        err_code_d = ERR_BRANCH;
                    end else if (in_class == CLASS_DP && in_imm) begin
                        state_d = StSearch;
                    end else begin
                        state_d = StEmit;
                        we_d    = 1'b1;
                        wdata_d = packed_word;
                    end
                end
            end
            StSearch: begin
                if (hit) begin
                    state_d = StEmit;
                    we_d    = 1'b1;
                    wdata_d = packed_word;
                end else if (rot_q == 4'd15) begin
                    state_d    = StErr;
                    err_d      = 1'b1;
                    err_code_d = ERR_NOIMM;
                end else begin
                    rot_d = rot_q + 4'd1;
                end
            end
            StEmit: begin
                addr_d  = addr_q + 32'd4;
                state_d = StIdle;
            end
            StErr: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            req_q      <= '0;
            addr_q     <= BASE_ADDR;
            rot_q      <= 4'd0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            rot_q      <= rot_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed requests push expected writes/errors,
// a negedge monitor pops and compares them, including the cycle they appear on.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        restart = 1'b0;
    logic        in_valid = 1'b0;
    req_t        req = '0;
    logic        in_ready, imem_we, err;
    logic [31:0] imem_addr, imem_wdata;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_class   (req.cls),
        .in_cond    (req.cond),
        .in_cmd     (req.cmd),
        .in_s       (req.s),
        .in_imm     (req.imm),
        .in_load    (req.load),
        .in_rn      (req.rn),
        .in_rd      (req.rd),
        .in_rm      (req.rm),
        .in_imm32   (req.imm32),
        .in_target  (req.target),
        .in_ready   (in_ready),
        .restart    (restart),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .err        (err),
        .err_code   (err_code)
    );

    typedef struct {
        logic        is_err;
        logic [1:0]  code;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] model_addr = BASE;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && (imem_we || err)) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {30'b0, imem_we, err}, 32'h0);
            end else begin
                e = sb.pop_front();
                check("strobe", {30'b0, imem_we, err}, e.is_err ? 32'h1 : 32'h2);
                check("addr", imem_addr, e.addr);
                if (e.is_err) check("err_code", {30'b0, err_code}, {30'b0, e.code});
                else          check("wdata", imem_wdata, e.wdata);
                check("latency", cyc, e.due);
            end
        end
    end

    function automatic req_t mk_dp(input logic [3:0] cmd, input logic s, input logic imm,
                                   input logic [3:0] rn, input logic [3:0] rd,
                                   input logic [3:0] rm, input logic [31:0] v);
        req_t r = '0;
        r.cls = CLASS_DP; r.cond = COND_AL; r.cmd = cmd; r.s = s; r.imm = imm;
        r.rn = rn; r.rd = rd; r.rm = rm; r.imm32 = v;
        return r;
    endfunction

    function automatic req_t mk_mem(input logic load, input logic [3:0] rn,
                                    input logic [3:0] rd, input logic [31:0] off);
        req_t r = '0;
        r.cls = CLASS_MEM; r.cond = COND_AL; r.load = load; r.rn = rn; r.rd = rd;
        r.imm32 = off;
        return r;
    endfunction

    function automatic req_t mk_br(input logic [1:0] cls, input logic [31:0] target);
        req_t r = '0;
        r.cls = cls; r.cond = COND_AL; r.target = target;
        return r;
    endfunction

    // Accept one request; expected output is due 'lat' cycles after the accept edge.
    task automatic issue(input req_t r, input logic rs, input logic exp_err,
                         input logic [1:0] code, input logic [31:0] wdata,
                         input int lat, input bit track);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", {31'b0, in_ready}, 32'h1);
        req = r;
        in_valid = 1'b1;
        restart = rs;
        if (rs) model_addr = BASE;
        if (track) begin
            sb.push_back('{exp_err, code, model_addr, wdata, cyc + lat});
            if (!exp_err) model_addr += 32'd4;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        restart = 1'b0;
        req = '0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, in_ready}, 32'h1);
        check("rst_addr", imem_addr, BASE);
        check("rst_we_err", {30'b0, imem_we, err}, 32'h0);
        check("rst_wdata", imem_wdata, 32'h0);
        check("rst_code", {30'b0, err_code}, 32'h0);
        rst_n = 1'b1;

        issue(mk_dp(CMD_ADD, 1'b0, 1'b0, 4'd2, 4'd1, 4'd3, 32'h0), 1'b0, 1'b0, 2'b00,
              32'hE082_1003, 1, 1'b1);
        drain();
        check("addr_after_add", imem_addr, 32'h4);

        issue(mk_dp(CMD_SUB, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 32'hFF00_0000), 1'b0, 1'b0,
              2'b00, 32'hE250_04FF, 6, 1'b1);
        issue(mk_dp(CMD_ADD, 1'b0, 1'b1, 4'd1, 4'd1, 4'd0, 32'h0000_0101), 1'b0, 1'b1,
              ERR_NOIMM, 32'h0, 17, 1'b1);
        drain();
        check("addr_after_miss", imem_addr, 32'h8);

        issue(mk_mem(1'b1, 4'd5, 4'd4, -32'sd8), 1'b0, 1'b0, 2'b00, 32'hE515_4008, 1, 1'b1);
        issue(mk_mem(1'b0, 4'd5, 4'd4, 32'd4096), 1'b0, 1'b1, ERR_MEMOFF, 32'h0, 1, 1'b1);
        issue(mk_dp(CMD_CMP, 1'b0, 1'b0, 4'd1, 4'd7, 4'd2, 32'h0), 1'b0, 1'b0, 2'b00,
              32'hE151_0002, 1, 1'b1);
        issue(mk_br(CLASS_BR, 32'h0), 1'b0, 1'b0, 2'b00, 32'hEAFF_FFFA, 1, 1'b1);
        issue(mk_br(CLASS_BR, 32'h2), 1'b0, 1'b1, ERR_BRANCH, 32'h0, 1, 1'b1);
        issue(mk_br(2'b11, 32'h0), 1'b0, 1'b1, ERR_DECODE, 32'h0, 1, 1'b1);
        issue(mk_dp(4'b0011, 1'b0, 1'b1, 4'd1, 4'd1, 4'd1, 32'h1), 1'b0, 1'b1, ERR_DECODE,
              32'h0, 1, 1'b1);
        drain();
        check("addr_before_restart", imem_addr, 32'h14);

        issue(mk_dp(CMD_EOR, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 32'h0), 1'b1, 1'b0, 2'b00,
              32'hE021_2003, 1, 1'b1);
        issue(mk_dp(CMD_ORR, 1'b0, 1'b1, 4'd1, 4'd2, 4'd0, 32'h0000_03F0), 1'b0, 1'b0,
              2'b00, 32'hE381_2E3F, 16, 1'b1);
        issue(mk_dp(CMD_AND, 1'b0, 1'b1, 4'd3, 4'd4, 4'd0, 32'h0000_0055), 1'b0, 1'b0,
              2'b00, 32'hE203_4055, 2, 1'b1);
        drain();
        check("addr_after_restart", imem_addr, 32'hC);

        issue(mk_dp(CMD_ADD, 1'b0, 1'b1, 4'd1, 4'd1, 4'd0, 32'h0000_0101), 1'b0, 1'b0,
              2'b00, 32'h0, 0, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("midreset_addr", imem_addr, BASE);
        check("midreset_we_err", {30'b0, imem_we, err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_addr = BASE;
        @(negedge clk);
        check("post_reset_ready", {31'b0, in_ready}, 32'h1);
        repeat (25) @(negedge clk);
        check("post_reset_addr", imem_addr, BASE);
        check("post_reset_sb", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
